// File: rtl/eq_sample_player.sv
// ROM-driven sample sequencer: streams base/length/stride address runs from a 1-cycle ROM into a valid/ready sink.
// Optional running checksum of accepted samples is enabled by defining EQ_SAMPLE_PLAYER_CHECKSUM_EN.
module eq_sample_player #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 10,
    parameter int STRIDE_WIDTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,          // asynchronous, active-low
    input  logic                    i_start,
    input  logic                    i_stop,
    input  logic                    i_loop_mode,
    input  logic [ADDR_WIDTH-1:0]   i_base_addr,
    input  logic [ADDR_WIDTH:0]     i_length,
    input  logic [STRIDE_WIDTH-1:0] i_stride,
    output logic [ADDR_WIDTH-1:0]   o_rom_addr,
    input  logic [DATA_WIDTH-1:0]   i_rom_data,
    output logic [DATA_WIDTH-1:0]   o_out_data,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [ADDR_WIDTH:0]     o_sample_count
`ifdef EQ_SAMPLE_PLAYER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH+ADDR_WIDTH:0] o_checksum
`endif
);

    localparam int CW = DATA_WIDTH + ADDR_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LOAD, S_VALID} state_t;

    state_t                  r_state,        w_state;
    logic [ADDR_WIDTH-1:0]   r_rom_addr,     w_rom_addr;
    logic [DATA_WIDTH-1:0]   r_out_data,     w_out_data;
    logic                    r_out_valid,    w_out_valid;
    logic                    r_busy,         w_busy;
    logic                    r_done,         w_done;
    logic [ADDR_WIDTH:0]     r_sample_count, w_sample_count;
    logic [ADDR_WIDTH-1:0]   r_base,         w_base;
    logic [ADDR_WIDTH:0]     r_length,       w_length;
    logic [STRIDE_WIDTH-1:0] r_stride,       w_stride;
    logic                    r_loop,         w_loop;
    logic [CW-1:0]           r_checksum,     w_checksum;

    logic                    w_accept;
    logic [ADDR_WIDTH:0]     w_count_inc;
    logic                    w_last;

    assign w_accept    = (r_state == S_VALID) && r_out_valid && i_out_ready;
    assign w_count_inc = r_sample_count + 1'b1;
    assign w_last      = (w_count_inc == r_length);

    always_comb begin
        // NOTE: every next-value gets a default first so no path leaves a signal unassigned (no latches).
        w_state        = r_state;
        w_rom_addr     = r_rom_addr;
        w_out_data     = r_out_data;
        w_out_valid    = r_out_valid;
        w_busy         = r_busy;
        w_done         = 1'b0;
        w_sample_count = r_sample_count;
        w_base         = r_base;
        w_length       = r_length;
        w_stride       = r_stride;
        w_loop         = r_loop;
        w_checksum     = r_checksum;

        unique case (r_state)
            S_IDLE: begin
                if (i_start && !i_stop && (i_length != '0)) begin
                    w_base         = i_base_addr;
                    w_length       = i_length;
                    // A zero stride would replay one address forever; treat it as unit stride.
                    w_stride       = (i_stride == '0) ? STRIDE_WIDTH'(1) : i_stride;
                    w_loop         = i_loop_mode;
                    w_sample_count = '0;
                    w_rom_addr     = i_base_addr;
                    w_busy         = 1'b1;
                    w_checksum     = '0;
                    w_state        = S_ADDR;
                end
            end
            S_ADDR: begin
                w_state = S_LOAD;
                if (i_stop) begin
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
                end
            end
            S_LOAD: begin
                if (i_stop) begin
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
                end else begin
                    w_out_data  = i_rom_data;
                    w_out_valid = 1'b1;
                    w_state     = S_VALID;
                end
            end
            S_VALID: begin
                if (w_accept) begin
                    w_out_valid    = 1'b0;
                    w_sample_count = w_count_inc;
                    w_checksum     = r_checksum + CW'(r_out_data);
                    if (i_stop) begin
                        // Accepted sample still counts; done only if it closed a one-shot pass.
                        w_done  = w_last && !r_loop;
                        w_busy  = 1'b0;
                        w_state = S_IDLE;
                    end else if (!w_last) begin
                        w_rom_addr = r_rom_addr + ADDR_WIDTH'(r_stride);
                        w_state    = S_ADDR;
                    end else if (r_loop) begin
                        w_done         = 1'b1;
                        w_sample_count = '0;
                        w_rom_addr     = r_base;
                        w_state        = S_ADDR;
                    end else begin
                        w_done  = 1'b1;
                        w_busy  = 1'b0;
                        w_state = S_IDLE;
                    end
                end else if (i_stop) begin
                    w_out_valid = 1'b0;
                    w_busy      = 1'b0;
                    w_state     = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state        <= S_IDLE;
            r_rom_addr     <= '0;
            r_out_data     <= '0;
            r_out_valid    <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_sample_count <= '0;
            r_base         <= '0;
            r_length       <= '0;
            r_stride       <= '0;
            r_loop         <= 1'b0;
            r_checksum     <= '0;
        end else begin
            r_state        <= w_state;
            r_rom_addr     <= w_rom_addr;
            r_out_data     <= w_out_data;
            r_out_valid    <= w_out_valid;
            r_busy         <= w_busy;
            r_done         <= w_done;
            r_sample_count <= w_sample_count;
            r_base         <= w_base;
            r_length       <= w_length;
            r_stride       <= w_stride;
            r_loop         <= w_loop;
            r_checksum     <= w_checksum;
        end
    end

    assign o_rom_addr     = r_rom_addr;
    assign o_out_data     = r_out_data;
    assign o_out_valid    = r_out_valid;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_sample_count = r_sample_count;

`ifdef EQ_SAMPLE_PLAYER_CHECKSUM_EN
    assign o_checksum = r_checksum;
`else
    logic w_unused_checksum;
    assign w_unused_checksum = ^r_checksum;
`endif

endmodule

// File: tb/tb_eq_sample_player.sv
// Directed bench for eq_sample_player: table of one-shot runs plus hand sequences for backpressure, loop/stop, reset and start corner cases.
module tb_eq_sample_player;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stop, loop_mode, out_ready;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic [3:0]  stride;
    logic [9:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  out_data;
    logic        out_valid, busy, done;
    logic [10:0] sample_count;
`ifdef EQ_SAMPLE_PLAYER_CHECKSUM_EN
    logic [18:0] checksum;
`endif

    int checks = 0;
    int errors = 0;

    eq_sample_player dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .i_stop         (stop),
        .i_loop_mode    (loop_mode),
        .i_base_addr    (base_addr),
        .i_length       (length),
        .i_stride       (stride),
        .o_rom_addr     (rom_addr),
        .i_rom_data     (rom_data),
        .o_out_data     (out_data),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_busy         (busy),
        .o_done         (done),
        .o_sample_count (sample_count)
`ifdef EQ_SAMPLE_PLAYER_CHECKSUM_EN
        ,
        .o_checksum     (checksum)
`endif
    );

    always #5 clk = ~clk;

    // ROM model: rom[a] = a[7:0], one-cycle read latency
    always @(posedge clk) rom_data <= rom_addr[7:0];

    typedef struct packed {
        logic [9:0]       base;
        logic [10:0]      length;
        logic [3:0]       stride;
        logic [3:0][9:0]  addr;
        logic [3:0][7:0]  data;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic do_start(input logic [9:0] b, input logic [10:0] l, input logic [3:0] s, input logic lp);
        base_addr = b; length = l; stride = s; loop_mode = lp; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        do_start(v.base, v.length, v.stride, 1'b0);
        check($sformatf("v%0d busy_after_start", idx), 32'(busy), 32'd1);
        check($sformatf("v%0d addr_after_start", idx), 32'(rom_addr), 32'(v.base));
`ifdef EQ_SAMPLE_PLAYER_CHECKSUM_EN
        check($sformatf("v%0d checksum_cleared", idx), 32'(checksum), 32'd0);
`endif
        for (int i = 0; i < int'(v.length); i++) begin
            wait_valid(lat);
            check($sformatf("v%0d latency%0d", idx, i), 32'(lat), 32'd2);
            check($sformatf("v%0d addr%0d", idx, i), 32'(rom_addr), 32'(v.addr[i]));
            check($sformatf("v%0d data%0d", idx, i), 32'(out_data), 32'(v.data[i]));
            tick();
            check($sformatf("v%0d done%0d", idx, i), 32'(done), 32'(i == int'(v.length) - 1));
            check($sformatf("v%0d count%0d", idx, i), 32'(sample_count), 32'(i + 1));
            check($sformatf("v%0d valid_drop%0d", idx, i), 32'(out_valid), 32'd0);
        end
        check($sformatf("v%0d busy_end", idx), 32'(busy), 32'd0);
        tick();
        check($sformatf("v%0d done_one_cycle", idx), 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        vecs[0] = '{base: 10'd0,    length: 11'd4, stride: 4'd1,
                    addr: {10'd3, 10'd2, 10'd1, 10'd0},
                    data: {8'h03, 8'h02, 8'h01, 8'h00}};
        vecs[1] = '{base: 10'd1020, length: 11'd3, stride: 4'd3,
                    addr: {10'd0, 10'd2, 10'd1023, 10'd1020},
                    data: {8'h00, 8'h02, 8'hFF, 8'hFC}};
        vecs[2] = '{base: 10'd5,    length: 11'd2, stride: 4'd0,
                    addr: {10'd0, 10'd0, 10'd6, 10'd5},
                    data: {8'h00, 8'h00, 8'h06, 8'h05}};
        vecs[3] = '{base: 10'd1000, length: 11'd1, stride: 4'd7,
                    addr: {10'd0, 10'd0, 10'd0, 10'd1000},
                    data: {8'h00, 8'h00, 8'h00, 8'hE8}};
        vecs[4] = '{base: 10'd300,  length: 11'd4, stride: 4'd15,
                    addr: {10'd345, 10'd330, 10'd315, 10'd300},
                    data: {8'h59, 8'h4A, 8'h3B, 8'h2C}};

        reset = 1'b0; start = 1'b0; stop = 1'b0; loop_mode = 1'b0; out_ready = 1'b1;
        base_addr = '0; length = '0; stride = '0;
        #1;
        check("reset rom_addr", 32'(rom_addr), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset count", 32'(sample_count), 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            run_vec(vecs[v], v);
`ifdef EQ_SAMPLE_PLAYER_CHECKSUM_EN
            if (v == 0) check("checksum first run", 32'(checksum), 32'd6);
`endif
        end

        // Backpressure: hold out_ready low for 5 cycles while a sample is pending
        out_ready = 1'b0;
        do_start(10'd7, 11'd2, 4'd1, 1'b0);
        wait_valid(lat);
        check("bp latency", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp hold_data%0d", i), 32'(out_data), 32'h07);
            check($sformatf("bp hold_valid%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("bp hold_addr%0d", i), 32'(rom_addr), 32'd7);
        end
        out_ready = 1'b1;
        tick();
        check("bp accepted_count", 32'(sample_count), 32'd1);
        check("bp accepted_valid", 32'(out_valid), 32'd0);
        check("bp next_addr", 32'(rom_addr), 32'd8);
        wait_valid(lat);
        check("bp data1", 32'(out_data), 32'h08);
        tick();
        check("bp done", 32'(done), 32'd1);
        check("bp busy", 32'(busy), 32'd0);
        tick();

        // Loop mode, then stop with a pending (unaccepted) sample
        do_start(10'd10, 11'd2, 4'd1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            wait_valid(lat);
            check($sformatf("loop latency%0d", i), 32'(lat), 32'd2);
            check($sformatf("loop data%0d", i), 32'(out_data), (i % 2 == 1) ? 32'h0B : 32'h0A);
            tick();
            check($sformatf("loop done%0d", i), 32'(done), 32'(i % 2 == 1));
            check($sformatf("loop busy%0d", i), 32'(busy), 32'd1);
        end
        wait_valid(lat);
        check("loop data4", 32'(out_data), 32'h0A);
        out_ready = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop valid", 32'(out_valid), 32'd0);
        check("stop busy", 32'(busy), 32'd0);
        check("stop done", 32'(done), 32'd0);
        tick(); tick();
        check("stop stays idle", 32'(out_valid | busy | done), 32'd0);
        out_ready = 1'b1; loop_mode = 1'b0;

        // stop and accept on the same edge for the last sample of a one-shot pass
        do_start(10'd0, 11'd1, 4'd1, 1'b0);
        wait_valid(lat);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stopacc done", 32'(done), 32'd1);
        check("stopacc count", 32'(sample_count), 32'd1);
        check("stopacc busy", 32'(busy), 32'd0);
        tick();

        // length 0: start ignored
        do_start(10'd33, 11'd0, 4'd1, 1'b0);
        check("len0 busy", 32'(busy), 32'd0);
        tick(); tick(); tick();
        check("len0 idle", 32'(busy | out_valid | done), 32'd0);

        // start held while busy with changed config: no restart
        base_addr = 10'd20; length = 11'd3; stride = 4'd2; start = 1'b1;
        tick();
        base_addr = 10'd100; length = 11'd4; stride = 4'd5;
        for (int i = 0; i < 3; i++) begin
            wait_valid(lat);
            check($sformatf("busystart latency%0d", i), 32'(lat), 32'd2);
            check($sformatf("busystart data%0d", i), 32'(out_data), 32'(20 + 2 * i));
            if (i == 2) start = 1'b0;
            tick();
            check($sformatf("busystart done%0d", i), 32'(done), 32'(i == 2));
        end
        check("busystart busy_end", 32'(busy), 32'd0);
        check("busystart count", 32'(sample_count), 32'd3);
        start = 1'b0;
        tick();

        // Asynchronous reset in the middle of VALID
        out_ready = 1'b0;
        do_start(10'd50, 11'd2, 4'd1, 1'b0);
        wait_valid(lat);
        check("rst pre valid", 32'(out_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst addr", 32'(rom_addr), 32'd0);
        check("rst data", 32'(out_data), 32'd0);
        check("rst valid", 32'(out_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst count", 32'(sample_count), 32'd0);
        check("rst done", 32'(done), 32'd0);
        tick();
        reset = 1'b1; out_ready = 1'b1;
        tick();
        check("rst stays idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
